// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_pkg;

  localparam int unsigned ENTRY_W   = 9;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_DIVW  = 16;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_CAPT = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       frm_err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX FIFO: registered head, count and full/empty flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        count
);

  localparam int unsigned CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      rd_ptr_inc;
  logic [CW-1:0]      count_next;
  logic               do_push;
  logic               do_pop;

  assign do_pop     = rd_en && !empty;
  assign do_push    = wr_en && (!full || do_pop);
  assign rd_ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + CW'(1);
    else if (!do_push && do_pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Head register tracks the next entry; bypass when the new head is being written now.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
      if (do_pop)
        rd_data <= (do_push && (rd_ptr_inc == wr_ptr)) ? wr_data : mem[rd_ptr_inc];
      else if (do_push && empty)
        rd_data <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: baud divider, enable/reset control, frame capture and sticky errors.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = 2,
  parameter int unsigned DIVW  = DEF_DIVW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic [DIVW-1:0]    cfg_div,
  input  logic               err_clr,
  input  logic               rd_en,
  input  logic               rx_done,
  input  logic               rx_busy,
  input  logic               rx_error,
  input  logic [7:0]         rx_byte,
  output logic               rx_en,
  output logic               rx_rst,
  output logic               bclk_tick,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [AW:0]        fifo_count,
  output logic               ovr_err,
  output logic               frm_err,
  output logic               line_busy
);

  rx_state_e       state;
  rx_state_e       state_next;
  logic [7:0]      hold_byte;
  logic [DIVW-1:0] div_cnt;
  logic            push_c;
  logic            ovr_set_c;
  logic            frm_set_c;
  rx_entry_t       entry_c;

  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:  if (cfg_en) state_next = ST_RUN;
      ST_RUN:  if (rx_done) state_next = ST_CAPT;
      ST_CAPT: state_next = ST_RUN;
      default: state_next = ST_OFF;
    endcase
    if (!cfg_en) state_next = ST_OFF;
  end

  // A capture cycle with the enable dropped is abandoned entirely.
  assign push_c    = (state == ST_CAPT) && cfg_en;
  assign ovr_set_c = push_c && fifo_full && !rd_en;
  assign frm_set_c = push_c && rx_error;
  assign entry_c   = '{frm_err: rx_error, data: hold_byte};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      hold_byte <= '0;
      rx_en     <= 1'b0;
      rx_rst    <= 1'b1;
      div_cnt   <= '0;
      bclk_tick <= 1'b0;
      ovr_err   <= 1'b0;
      frm_err   <= 1'b0;
      line_busy <= 1'b0;
    end else begin
      state     <= state_next;
      rx_en     <= (state_next != ST_OFF);
      rx_rst    <= (state_next == ST_OFF);
      line_busy <= rx_busy;
      if (state == ST_RUN && rx_done) hold_byte <= rx_byte;

      // Divider held at the reload value while off so re-enable starts a full period.
      if (state_next == ST_OFF) begin
        div_cnt   <= cfg_div;
        bclk_tick <= 1'b0;
      end else if (div_cnt == '0) begin
        div_cnt   <= cfg_div;
        bclk_tick <= 1'b1;
      end else begin
        div_cnt   <= div_cnt - DIVW'(1);
        bclk_tick <= 1'b0;
      end

      if (ovr_set_c)    ovr_err <= 1'b1;
      else if (err_clr) ovr_err <= 1'b0;
      if (frm_set_c)    frm_err <= 1'b1;
      else if (err_clr) frm_err <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_c),
    .wr_data (entry_c),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with hand-computed expectations.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        err_clr;
  logic        rd_en;
  logic        rx_done;
  logic        rx_busy;
  logic        rx_error;
  logic [7:0]  rx_byte;
  logic        rx_en;
  logic        rx_rst;
  logic        bclk_tick;
  logic [8:0]  rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic        ovr_err;
  logic        frm_err;
  logic        line_busy;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(4), .AW(2), .DIVW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .cfg_div    (cfg_div),
    .err_clr    (err_clr),
    .rd_en      (rd_en),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .rx_error   (rx_error),
    .rx_byte    (rx_byte),
    .rx_en      (rx_en),
    .rx_rst     (rx_rst),
    .bclk_tick  (bclk_tick),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .ovr_err    (ovr_err),
    .frm_err    (frm_err),
    .line_busy  (line_busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic e);
    rx_done = 1'b1; rx_byte = b;
    step(1);
    rx_done = 1'b0; rx_error = e;
    step(1);
    rx_error = 1'b0;
  endtask

  task automatic pop;
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_en = 1'b0; cfg_div = 16'd3; err_clr = 1'b0; rd_en = 1'b0;
    rx_done = 1'b0; rx_busy = 1'b0; rx_error = 1'b0; rx_byte = 8'h00;
    step(2);
    rst_n = 1'b1;
    step(1);
    tests++;
    if ({rx_en, rx_rst, bclk_tick, fifo_empty, fifo_full, ovr_err, frm_err, line_busy} !== 8'b0101_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 01010000",
               {rx_en, rx_rst, bclk_tick, fifo_empty, fifo_full, ovr_err, frm_err, line_busy});
    end
    tests++;
    if (fifo_count !== 3'd0 || rd_data !== 9'h000) begin
      errors++;
      $display("FAIL reset_fifo: got count=%0d data=%h expected 0/000", fifo_count, rd_data);
    end
  endtask

  task automatic test_enable;
    cfg_en = 1'b1;
    tests++;
    if (rx_rst !== 1'b1 || rx_en !== 1'b0) begin
      errors++;
      $display("FAIL pre_enable: got rx_rst=%b rx_en=%b expected 1/0", rx_rst, rx_en);
    end
    step(1);
    tests++;
    if (rx_rst !== 1'b0 || rx_en !== 1'b1) begin
      errors++;
      $display("FAIL post_enable: got rx_rst=%b rx_en=%b expected 0/1", rx_rst, rx_en);
    end
    // cfg_div=3: ticks land on the 4th, 8th and 12th edges after the enabling edge.
    for (int k = 1; k <= 12; k++) begin
      logic exp_tick;
      if (k > 1) step(1);
      exp_tick = (k % 4 == 0);
      tests++;
      if (bclk_tick !== exp_tick) begin
        errors++;
        $display("FAIL tick_div3[%0d]: got %b expected %b", k, bclk_tick, exp_tick);
      end
    end
    rx_busy = 1'b1;
    step(1);
    tests++;
    if (line_busy !== 1'b1) begin
      errors++;
      $display("FAIL line_busy: got %b expected 1", line_busy);
    end
    rx_busy = 1'b0;
    step(1);
  endtask

  task automatic test_single;
    send_frame(8'hA5, 1'b0);
    tests++;
    if (rd_data !== 9'h0A5 || fifo_count !== 3'd1 || frm_err !== 1'b0 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_push: got data=%h count=%0d frm=%b empty=%b expected 0a5/1/0/0",
               rd_data, fifo_count, frm_err, fifo_empty);
    end
    pop();
    tests++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: got empty=%b count=%0d expected 1/0", fifo_empty, fifo_count);
    end
    pop();
    tests++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL empty_pop: got empty=%b count=%0d expected 1/0", fifo_empty, fifo_count);
    end
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b1);
    tests++;
    if (rd_data !== 9'h13C || frm_err !== 1'b1) begin
      errors++;
      $display("FAIL frm_push: got data=%h frm=%b expected 13c/1", rd_data, frm_err);
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    tests++;
    if (frm_err !== 1'b0 || rd_data !== 9'h13C || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL frm_clear: got frm=%b data=%h count=%0d expected 0/13c/1", frm_err, rd_data, fifo_count);
    end
    pop();
    // Set and clear in the same cycle: set wins.
    rx_done = 1'b1; rx_byte = 8'h5A;
    step(1);
    rx_done = 1'b0; rx_error = 1'b1; err_clr = 1'b1;
    step(1);
    rx_error = 1'b0; err_clr = 1'b0;
    tests++;
    if (frm_err !== 1'b1 || rd_data !== 9'h15A) begin
      errors++;
      $display("FAIL set_wins: got frm=%b data=%h expected 1/15a", frm_err, rd_data);
    end
    err_clr = 1'b1;
    pop();
    err_clr = 1'b0;
  endtask

  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0);
    tests++;
    if (fifo_full !== 1'b1 || ovr_err !== 1'b1 || fifo_count !== 3'd4 || frm_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun: got full=%b ovr=%b count=%0d frm=%b expected 1/1/4/0",
               fifo_full, ovr_err, fifo_count, frm_err);
    end
    for (int i = 1; i <= 4; i++) begin
      logic [8:0] exp_d;
      exp_d = 9'(i);
      tests++;
      if (rd_data !== exp_d) begin
        errors++;
        $display("FAIL ovr_order[%0d]: got %h expected %h", i, rd_data, exp_d);
      end
      pop();
    end
    tests++;
    if (fifo_empty !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL ovr_drain: got empty=%b count=%0d expected 1/0", fifo_empty, fifo_count);
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    tests++;
    if (ovr_err !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b expected 0", ovr_err);
    end
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0);
    rx_done = 1'b1; rx_byte = 8'h14;
    step(1);
    rx_done = 1'b0; rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    tests++;
    if (ovr_err !== 1'b0 || fifo_count !== 3'd4 || fifo_full !== 1'b1 || rd_data !== 9'h011) begin
      errors++;
      $display("FAIL full_push_pop: got ovr=%b count=%0d full=%b data=%h expected 0/4/1/011",
               ovr_err, fifo_count, fifo_full, rd_data);
    end
    for (int i = 1; i <= 4; i++) begin
      logic [8:0] exp_d;
      exp_d = 9'h010 + 9'(i);
      tests++;
      if (rd_data !== exp_d) begin
        errors++;
        $display("FAIL full_pop_order[%0d]: got %h expected %h", i, rd_data, exp_d);
      end
      pop();
    end
    tests++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_drain: got empty=%b expected 1", fifo_empty);
    end
  endtask

  task automatic test_disable;
    rx_busy = 1'b1;
    rx_done = 1'b1; rx_byte = 8'h77;
    step(1);
    rx_done = 1'b0; cfg_en = 1'b0;
    step(1);
    rx_busy = 1'b0;
    tests++;
    if (rx_rst !== 1'b1 || rx_en !== 1'b0 || bclk_tick !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL disable: got rst=%b en=%b tick=%b count=%0d expected 1/0/0/0",
               rx_rst, rx_en, bclk_tick, fifo_count);
    end
    cfg_div = 16'd2;
    step(3);
    tests++;
    if (bclk_tick !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL off_idle: got tick=%b empty=%b expected 0/1", bclk_tick, fifo_empty);
    end
    cfg_en = 1'b1;
    // cfg_div=2: first tick cfg_div+1 = 3 edges after re-enable, then every 3.
    for (int k = 1; k <= 6; k++) begin
      logic exp_tick;
      step(1);
      exp_tick = (k % 3 == 0);
      tests++;
      if (bclk_tick !== exp_tick) begin
        errors++;
        $display("FAIL tick_reen[%0d]: got %b expected %b", k, bclk_tick, exp_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_single();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver datapath: generates its baud tick, gates its enable, and holds it in reset while disabled. On each completed frame it captures the received byte and that frame's framing status into a small show-ahead RX FIFO. It keeps sticky overrun and framing error flags for the APB register layer. It sits between the APB register block and the UART receiver.

Parameters:
DEPTH, 4, RX FIFO entries (power of two, >= 2)
AW, 2, log2(DEPTH)
DIVW, 16, baud divisor width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cfg_en  in  1  receive enable from control register
cfg_div  in  DIVW  baud divisor; tick period = cfg_div+1 clk cycles
err_clr  in  1  one-cycle pulse; clears sticky error flags
rd_en  in  1  pop FIFO head
rx_done  in  1  receiver frame-complete pulse
rx_busy  in  1  receiver mid-frame indicator
rx_error  in  1  receiver framing error; valid the cycle after rx_done
rx_byte  in  8  receiver output byte; valid with rx_done
rx_en  out  1  receiver enable
rx_rst  out  1  receiver synchronous clear
bclk_tick  out  1  one-clk baud strobe to the receiver BCLK input
rd_data  out  9  FIFO head {frm_err, byte}; show-ahead
fifo_empty  out  1  FIFO has no entries
fifo_full  out  1  FIFO has DEPTH entries
fifo_count  out  AW+1  occupancy, 0..DEPTH
ovr_err  out  1  sticky: a frame was dropped because the FIFO was full
frm_err  out  1  sticky: a frame was captured with rx_error=1
line_busy  out  1  rx_busy registered, for status

Behaviour:
- Reset values (rst_n=0 at a clk edge): state=OFF, rx_en=0, rx_rst=1, bclk_tick=0, divider counter=0, FIFO empty, fifo_count=0, rd_data=0, ovr_err=0, frm_err=0, line_busy=0.
- Baud divider: counter counts down while state != OFF. bclk_tick=1 for exactly one cycle when the counter is 0, and the counter reloads from cfg_div in that same cycle. cfg_div=0 gives a tick every cycle. A cfg_div change takes effect at the next reload. In OFF the counter is held at cfg_div and bclk_tick=0.
- FSM states: OFF, RUN, CAPT.
  - OFF: rx_en=0, rx_rst=1. Go to RUN when cfg_en=1.
  - RUN: rx_en=1, rx_rst=0. On rx_done=1, latch rx_byte into hold_byte and go to CAPT.
  - CAPT: lasts one cycle. Sample rx_error and attempt push of {rx_error, hold_byte}. Return to RUN.
  - cfg_en=0 in any state goes to OFF next cycle and aborts any partial frame, with no push. cfg_en=0 while in CAPT drops the capture.
- Push rules in CAPT:
  - If not full, or full with rd_en=1 in the same cycle, the entry is written. fifo_count is unchanged when a push and a pop occur together.
  - If full with no pop, the entry is discarded and ovr_err is set.
  - frm_err is set when rx_error=1, whether the entry was pushed or dropped.
- Pop: rd_en with fifo_empty=1 is ignored; pointers and count do not change. rd_data always shows the head entry. It is updated the cycle after a push into an empty FIFO, or the cycle after a pop.
- Pointers wrap modulo DEPTH. fifo_full = (count==DEPTH). fifo_empty = (count==0).
- Sticky flags clear on err_clr=1. If a set event and err_clr happen in the same cycle, set wins.
- rx_done while in CAPT cannot occur (frames are at least 10 ticks apart) and is ignored.
- The FIFO keeps its contents across OFF; only rst_n clears it.

Decomposition:
- Package uart_pkg: FSM state encoding (OFF=2'd0, RUN=2'd1, CAPT=2'd2), FIFO entry width constant (9), default DEPTH/DIVW.
- Sub-module uart_rx_fifo (parameters DEPTH/AW, width 9). It implements push, pop, count, full, empty and show-ahead rd_data, with sync active-low reset.
- The divider and FSM stay in uart_rx_ctrl.

Test Plan:
- Reset, then cfg_en=1, cfg_div=3: bclk_tick pulses every 4 clks; rx_en=1 and rx_rst=0 from the 2nd cycle after cfg_en; before that rx_rst=1.
- rx_done with rx_byte=0xA5, then rx_error=0 next cycle: rd_data=0x0A5, fifo_count=1, frm_err=0. rd_en pops the entry: fifo_empty=1.
- rx_done with 0x3C, then rx_error=1: rd_data=0x13C, frm_err=1. A following err_clr clears frm_err; the FIFO entry is unchanged.
- Five frames 0x01..0x05 with DEPTH=4 and no reads: fifo_full=1, ovr_err=1. Pops return 0x001..0x004 in order, then fifo_empty.
- FIFO full, and the CAPT cycle coincides with rd_en=1: no overrun, count stays 4, head advances to the next entry.
- cfg_en drops while rx_busy=1: next cycle state=OFF, rx_rst=1, bclk_tick=0, no push. Re-enable resumes ticking after cfg_div+1 clks.
